// File: rtl/framer_pkg.sv
// Shared types and default byte values for the byte stream framer.
// Used by byte_stream_framer and framer_out_slot.
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        PAD,
        CSUM
    } framer_state_t;

    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;
    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    // Two's complement of the running sum, so payload + checksum == 0 mod 256.
    function automatic logic [7:0] csum_byte(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/framer_out_slot.sv
// Single-entry registered output stage of the framer: holds one byte with
// its sof/eof marks until the downstream accepts it.
module framer_out_slot (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_load_sof,
    input  logic       i_load_eof,
    input  logic       i_ready,
    output logic       o_slot_free,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_sof,
    output logic       o_eof
);

    assign o_slot_free = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= 8'h00;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end else if (i_load && o_slot_free) begin
            o_valid <= 1'b1;
            o_data  <= i_load_data;
            o_sof   <= i_load_sof;
            o_eof   <= i_load_eof;
        end else if (i_ready) begin
            // Byte taken with nothing behind it: data is left as-is.
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_stream_framer.sv
// Packs bytes from a FWFT FIFO into header/payload/checksum frames, padding
// stalled frames after an idle timeout. BYTE_STREAM_FRAMER_STATS_EN adds counters.
//
// state   | meaning
// IDLE    | no frame in progress, waiting for the FIFO to go non-empty
// HDR     | loading the SOF header byte
// PAYLOAD | popping FIFO bytes into the frame, timeout armed after first byte
// PAD     | source stalled too long, filling remaining payload with PAD_BYTE
// CSUM    | loading the checksum byte that closes the frame
module byte_stream_framer
    import framer_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter logic [7:0]  SOF_BYTE    = DEF_SOF_BYTE,
    parameter logic [7:0]  PAD_BYTE    = DEF_PAD_BYTE,
    parameter int          TIMEOUT     = 16,
    parameter int          TO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd_empty,
    input  logic [7:0]  i_rd_data,
    output logic        o_read,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_sof,
    output logic        o_eof,
    input  logic        i_ready,
    output logic        o_busy
`ifdef BYTE_STREAM_FRAMER_STATS_EN
   ,output logic [15:0] o_frame_cnt,
    output logic [15:0] o_pad_cnt
`endif
);

    localparam logic [7:0]      LEN_LAST = 8'(PAYLOAD_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    framer_state_t   state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [TO_W-1:0] to_q, to_d;

    logic            slot_free;
    logic            load;
    logic [7:0]      load_data;
    logic            load_sof;
    logic            load_eof;
    logic            rd;

    framer_out_slot u_out_slot (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (load),
        .i_load_data (load_data),
        .i_load_sof  (load_sof),
        .i_load_eof  (load_eof),
        .i_ready     (i_ready),
        .o_slot_free (slot_free),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_sof       (o_sof),
        .o_eof       (o_eof)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            sum_q   <= 8'h00;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        to_d      = to_q;
        load      = 1'b0;
        load_data = 8'h00;
        load_sof  = 1'b0;
        load_eof  = 1'b0;
        rd        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_rd_empty) state_d = HDR;
            end
            HDR: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = SOF_BYTE;
                    load_sof  = 1'b1;
                    sum_d     = 8'h00;
                    cnt_d     = 8'h00;
                    to_d      = '0;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!i_rd_empty) begin
                    // Data present but blocked by backpressure neither pops nor ages the timer.
                    if (slot_free) begin
                        rd        = 1'b1;
                        load      = 1'b1;
                        load_data = i_rd_data;
                        sum_d     = sum_q + i_rd_data;
                        cnt_d     = cnt_q + 8'd1;
                        to_d      = '0;
                        if (cnt_q == LEN_LAST) state_d = CSUM;
                    end
                end else if (TIMEOUT != 0 && cnt_q != 8'h00) begin
                    if (to_q == TO_LAST) begin
                        to_d    = '0;
                        state_d = PAD;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = PAD_BYTE;
                    sum_d     = sum_q + PAD_BYTE;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_q == LEN_LAST) state_d = CSUM;
                end
            end
            CSUM: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = csum_byte(sum_q);
                    load_eof  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_read = rd;
    assign o_busy = (state_q != IDLE);

`ifdef BYTE_STREAM_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] pad_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q <= 16'h0000;
            pad_cnt_q   <= 16'h0000;
        end else begin
            if (o_valid && o_eof && i_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (state_q == PAD && slot_free) pad_cnt_q <= pad_cnt_q + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_pad_cnt   = pad_cnt_q;
`endif

endmodule

// File: tb/tb_byte_stream_framer.sv
// Scoreboard bench for byte_stream_framer: a FIFO model feeds the DUT and
// every accepted output beat is compared against the expected frame queue.
module tb_byte_stream_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rd_empty = 1'b1;
    logic [7:0]  i_rd_data = 8'h00;
    logic        i_ready = 1'b0;
    logic        o_read;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_sof;
    logic        o_eof;
    logic        o_busy;
`ifdef BYTE_STREAM_FRAMER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] pad_cnt;
`endif

    beat_t       exp_q[$];
    logic [7:0]  src_q[$];
    int          acc_cyc_q[$];
    beat_t       exp_b;
    bit          ready_ctl = 1'b0;
    bit          stall_ctl = 1'b0;
    int          cyc = 0;
    int          read_cnt = 0;
    int          last_pop_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    byte_stream_framer #(
        .PAYLOAD_LEN (4),
        .SOF_BYTE    (8'hA5),
        .PAD_BYTE    (8'h00),
        .TIMEOUT     (16),
        .TO_W        (8)
    ) dut (
`ifdef BYTE_STREAM_FRAMER_STATS_EN
        .o_frame_cnt (frame_cnt),
        .o_pad_cnt   (pad_cnt),
`endif
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rd_empty  (i_rd_empty),
        .i_rd_data   (i_rd_data),
        .o_read      (o_read),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .i_ready     (i_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // FIFO model and output monitor: inputs change on the falling edge, the
    // values seen 1 ns later are what the next rising edge will act on.
    always @(negedge clk) begin
        i_ready    = ready_ctl;
        i_rd_empty = stall_ctl || (src_q.size() == 0);
        i_rd_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
        #1;
        if (rst_n) begin
            if (o_read) begin
                read_cnt++;
                last_pop_cyc = cyc;
                if (src_q.size() != 0) void'(src_q.pop_front());
            end
            if (o_valid && i_ready) begin
                acc_cyc_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%02h sof=%0b eof=%0b, required no beat",
                             o_data, o_sof, o_eof);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({o_data, o_sof, o_eof} !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got data=%02h sof=%0b eof=%0b, required data=%02h sof=%0b eof=%0b",
                                 o_data, o_sof, o_eof, exp_b.data, exp_b.sof, exp_b.eof);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] p0, p1, p2, p3);
        logic [7:0] sum;
        sum = p0 + p1 + p2 + p3;
        exp_q.push_back({8'hA5, 1'b1, 1'b0});
        exp_q.push_back({p0, 1'b0, 1'b0});
        exp_q.push_back({p1, 1'b0, 1'b0});
        exp_q.push_back({p2, 1'b0, 1'b0});
        exp_q.push_back({p3, 1'b0, 1'b0});
        exp_q.push_back({8'h00 - sum, 1'b0, 1'b1});
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reads(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (read_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_data, o_sof, o_eof} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%02h sof=%0b eof=%0b, required all 0",
                     o_valid, o_data, o_sof, o_eof);
        end
        checks++;
        if ({o_busy, o_read} !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy_read: got busy=%0b read=%0b, required 0 0", o_busy, o_read);
        end
        ready_ctl = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        @(posedge clk); #1;
        read_cnt = 0;
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_exp(8'h01, 8'h02, 8'h03, 8'h04);
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (read_cnt !== 4) begin
            errors++;
            $display("FAIL basic_reads: got %0d, required 4", read_cnt);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%0b, required 0", o_busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(posedge clk); #1;
        read_cnt = 0;
        acc_cyc_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'h10 + 8'(i));
        push_exp(8'h10, 8'h11, 8'h12, 8'h13);
        push_exp(8'h14, 8'h15, 8'h16, 8'h17);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        checks++;
        if (read_cnt !== 8) begin
            errors++;
            $display("FAIL b2b_reads: got %0d, required 8", read_cnt);
        end
        checks++;
        if (acc_cyc_q.size() != 12) begin
            errors++;
            $display("FAIL b2b_beats: got %0d, required 12", acc_cyc_q.size());
        end else begin
            checks++;
            if (acc_cyc_q[5] - acc_cyc_q[0] != 5) begin
                errors++;
                $display("FAIL b2b_frame_len: got %0d cycles sof-to-eof, required 5",
                         acc_cyc_q[5] - acc_cyc_q[0]);
            end
            checks++;
            if (acc_cyc_q[6] - acc_cyc_q[5] != 2) begin
                errors++;
                $display("FAIL b2b_gap: got %0d cycles eof-to-sof, required 2",
                         acc_cyc_q[6] - acc_cyc_q[5]);
            end
        end
    endtask

    task automatic test_timeout_pad();
        bit ok;
        @(posedge clk); #1;
        read_cnt = 0;
        acc_cyc_q.delete();
        src_q = '{8'h10, 8'h20};
        push_exp(8'h10, 8'h20, 8'h00, 8'h00);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pad_drain: got %0d beats outstanding, required 0", exp_q.size());
        end
        checks++;
        if (read_cnt !== 2) begin
            errors++;
            $display("FAIL pad_reads: got %0d, required 2", read_cnt);
        end
        checks++;
        if (acc_cyc_q.size() < 4 || acc_cyc_q[3] - last_pop_cyc != 18) begin
            errors++;
            $display("FAIL pad_timing: got first pad %0d cycles after last pop, required 18",
                     (acc_cyc_q.size() < 4) ? -1 : acc_cyc_q[3] - last_pop_cyc);
        end
`ifdef BYTE_STREAM_FRAMER_STATS_EN
        checks++;
        if (pad_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats_pad_cnt: got %0d, required 2", pad_cnt);
        end
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stats_frame_cnt: got %0d, required 4", frame_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        int waited;
        @(posedge clk); #1;
        read_cnt = 0;
        ready_ctl = 1'b0;
        src_q = '{8'h40, 8'h41, 8'h42, 8'h43};
        push_exp(8'h40, 8'h41, 8'h42, 8'h43);
        waited = 0;
        while (o_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hdr_valid: got valid=%0b, required 1", o_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_valid, o_data, o_sof, o_read} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold: got valid=%0b data=%02h sof=%0b read=%0b, required 1 a5 1 0",
                         o_valid, o_data, o_sof, o_read);
            end
        end
        checks++;
        if (read_cnt !== 0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_stalled: got reads=%0d busy=%0b, required 0 1", read_cnt, o_busy);
        end
        ready_ctl = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok || read_cnt !== 4) begin
            errors++;
            $display("FAIL bp_complete: got reads=%0d outstanding=%0d, required 4 0",
                     read_cnt, exp_q.size());
        end
    endtask

    task automatic test_race();
        bit ok;
        int c_pop;
        int guard;
        @(posedge clk); #1;
        read_cnt = 0;
        src_q = '{8'h30};
        push_exp(8'h30, 8'h31, 8'h32, 8'h33);
        wait_reads(1, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL race_first_pop: got %0d reads, required 1", read_cnt);
        end
        c_pop = last_pop_cyc;
        guard = 0;
        while (cyc < c_pop + 16 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        // Next falling edge presents data for the edge that would otherwise expire the timer.
        src_q.push_back(8'h31);
        src_q.push_back(8'h32);
        src_q.push_back(8'h33);
        wait_drain(100, ok);
        checks++;
        if (!ok || read_cnt !== 4) begin
            errors++;
            $display("FAIL race_complete: got reads=%0d outstanding=%0d, required 4 0",
                     read_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        @(posedge clk); #1;
        read_cnt = 0;
        src_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        push_exp(8'h50, 8'h51, 8'h52, 8'h53);
        wait_reads(2, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_pops: got %0d reads, required 2", read_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_data, o_sof, o_eof, o_busy, o_read} !== 13'h0000) begin
            errors++;
            $display("FAIL rst_mid_outputs: got valid=%0b data=%02h sof=%0b eof=%0b busy=%0b read=%0b, required all 0",
                     o_valid, o_data, o_sof, o_eof, o_busy, o_read);
        end
        exp_q.delete();
        read_cnt = 0;
        push_exp(8'h52, 8'h53, 8'h54, 8'h55);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok || read_cnt !== 4) begin
            errors++;
            $display("FAIL rst_mid_refrm: got reads=%0d outstanding=%0d, required 4 0",
                     read_cnt, exp_q.size());
        end
`ifdef BYTE_STREAM_FRAMER_STATS_EN
        checks++;
        if (frame_cnt !== 16'd1 || pad_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_after_reset: got frames=%0d pads=%0d, required 1 0", frame_cnt, pad_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout_pad();
        test_backpressure();
        test_race();
        test_reset_mid_frame();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_stream_framer.md
Name: byte_stream_framer

Overview:
- Downstream stage of the round-robin merge FIFO (fifo_sync instance E).
- Drains that FIFO's first-word-fall-through read port and packs the bytes into fixed-length frames: header byte, PAYLOAD_LEN payload bytes, checksum byte.
- Emits frames on a registered valid/ready byte stream toward the link/serializer stage.
- A stalled source mid-frame is closed out with pad bytes after a programmable idle timeout.

Parameters:
- PAYLOAD_LEN, 4, payload bytes per frame; legal range 1..255.
- SOF_BYTE, 8'hA5, header byte value.
- PAD_BYTE, 8'h00, byte inserted on timeout.
- TIMEOUT, 16, consecutive empty cycles mid-payload before padding; 0 disables the timeout.
- TO_W, 8, timeout counter width; TIMEOUT must be < 2**TO_W.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rd_empty  input  1  upstream FIFO empty
- i_rd_data  input  8  upstream FIFO head data, valid same cycle when !i_rd_empty
- o_read  output  1  upstream pop strobe, combinational
- o_valid  output  1  output byte valid
- o_data  output  8  output byte
- o_sof  output  1  marks header byte
- o_eof  output  1  marks checksum byte
- i_ready  input  1  downstream accept
- o_busy  output  1  high when state != IDLE

Behaviour:
- Single clock domain: i_clk.
- Reset: asynchronous, active-low on i_rst_n. Reset is asserted asynchronously and released synchronously to i_clk.
- Reset values: o_valid=0, o_data=0, o_sof=0, o_eof=0, state=IDLE, byte count=0, checksum=0, timeout count=0.
- Output slot:
  - o_valid/o_data/o_sof/o_eof are registered.
  - slot_free = !o_valid || i_ready.
  - The slot loads a new byte only when slot_free; otherwise all four outputs hold stable.
  - o_valid clears when a byte is accepted and no new byte is loaded.
- States: IDLE, HDR, PAYLOAD, PAD, CSUM.
- IDLE -> HDR when !i_rd_empty. No FIFO pop.
- HDR: when slot_free, load SOF_BYTE with o_sof=1, clear checksum and count, then -> PAYLOAD.
- PAYLOAD:
  - o_read = !i_rd_empty && slot_free.
  - On o_read: load i_rd_data, checksum += i_rd_data (mod 256), count++.
  - When count reaches PAYLOAD_LEN -> CSUM.
- Timeout:
  - Active in PAYLOAD only, and only after at least one payload byte has been loaded.
  - Counts cycles with i_rd_empty=1; clears on any pop.
  - Reaching TIMEOUT -> PAD.
  - Backpressure with data available does not count.
- PAD: each slot_free cycle loads PAD_BYTE, adds it to the checksum, and counts it; -> CSUM at PAYLOAD_LEN. No FIFO pops in PAD.
- CSUM:
  - When slot_free, load (0 - checksum)[7:0] with o_eof=1, then -> IDLE.
  - Invariant: payload sum + checksum byte == 0 mod 256.
- o_read is never asserted outside PAYLOAD. Frames never interleave. Minimum frame gap is 1 cycle (IDLE).
- Simultaneous events:
  - Data arriving on the cycle the timeout expires is popped; the pop wins and the counter clears.
  - i_ready=0 with i_rd_empty=0: no pop and no timeout count.
- Reset mid-frame drops the partial frame. After reset the next frame starts with a fresh header.
- Throughput: one byte per cycle when i_ready=1 and the FIFO is non-empty. Frame length is PAYLOAD_LEN+2 beats.

Optional Feature:
- Macro: BYTE_STREAM_FRAMER_STATS_EN.
- Defined: adds outputs o_frame_cnt[15:0] and o_pad_cnt[15:0], both reset to 0.
  - o_frame_cnt increments when the checksum byte is accepted.
  - o_pad_cnt increments per PAD_BYTE loaded.
  - Both counters wrap at 16'hFFFF.
- Not defined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package framer_pkg holds:
  - typedef enum logic [2:0] framer_state_t {IDLE, HDR, PAYLOAD, PAD, CSUM};
  - localparams for default SOF_BYTE and PAD_BYTE.
- One natural sub-module: framer_out_slot, the single-entry registered output stage (load/hold/valid logic, slot_free). All other logic stays flat.

Test Plan:
- Basic frame: FIFO holds 01 02 03 04, i_ready=1 -> beats A5(sof) 01 02 03 04 F6(eof); exactly 4 o_read pulses.
- Back-to-back: 8 bytes 10..17 pre-loaded -> two frames with checksums 0xBA then 0xAA. Exactly one IDLE cycle between the first frame's eof and the second frame's sof.
- Timeout pad: push 10 20, then FIFO empty for 16 cycles -> A5 10 20 00 00 D0(eof). o_read stays low in PAD. With BYTE_STREAM_FRAMER_STATS_EN defined, o_pad_cnt=2.
- Backpressure: hold i_ready=0 for 20 cycles with the header valid -> o_data stays A5, o_read=0, no timeout or pad. After release the frame completes normally.
- Race: the byte arrives on the exact cycle the timeout count reaches 16 -> the byte is popped and no pad is inserted.
- Reset mid-frame: assert i_rst_n=0 after 2 payload bytes -> all outputs are 0 immediately. After release, the remaining FIFO bytes form a fresh frame starting with A5.
